// File: rtl/tri_bbox_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tri_bbox_scanner
// Purpose  : Walks the screen-clamped bounding box of one triangle in raster
//            order and emits recoded-float sample points for the point sampler.
// Revision : 1.0
// ============================================================================
module tri_bbox_scanner #(
  parameter int PIX_W    = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [65:0]      tri_Pa,
  input  logic [65:0]      tri_Pb,
  input  logic [65:0]      tri_Pc,
  input  logic [PIX_W-1:0] tri_xmin,
  input  logic [PIX_W-1:0] tri_xmax,
  input  logic [PIX_W-1:0] tri_ymin,
  input  logic [PIX_W-1:0] tri_ymax,
  input  logic             tri_windingOrder,
  input  logic             tri_origin_location,
  input  logic             tri_areaSign,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_x,
  output logic [PIX_W-1:0] pix_y,
  output logic [65:0]      pix_Pin,
  output logic [65:0]      pix_Pa,
  output logic [65:0]      pix_Pb,
  output logic [65:0]      pix_Pc,
  output logic             pix_windingOrder,
  output logic             pix_origin_location,
  output logic             pix_areaSign,
  output logic             pix_last,
  output logic             tri_done
);

  localparam logic [PIX_W-1:0] c_X_LIM = PIX_W'(SCREEN_W - 1);
  localparam logic [PIX_W-1:0] c_Y_LIM = PIX_W'(SCREEN_H - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [PIX_W-1:0] r_x;
  logic [PIX_W-1:0] r_y;
  logic [PIX_W-1:0] r_xmin;
  logic [PIX_W-1:0] r_cxmax;
  logic [PIX_W-1:0] r_cymax;
  logic             r_tri_ready;
  logic             r_pix_valid;
  logic             r_tri_done;
  logic [65:0]      r_pa;
  logic [65:0]      r_pb;
  logic [65:0]      r_pc;
  logic             r_wind;
  logic             r_orig;
  logic             r_area;

  logic [PIX_W-1:0] w_cxmax;
  logic [PIX_W-1:0] w_cymax;
  logic             w_empty;
  logic             w_accept;
  logic             w_adv;
  logic             w_x_end;
  logic             w_y_end;

  // Unsigned integer to recFN(8,24); exact because PIX_W <= 24.
  // Recoded exponent of 2^p is p + 256; zero encodes as all-zero.
  function automatic logic [32:0] f_int_to_rec(input logic [PIX_W-1:0] n);
    logic [4:0]  msb;
    logic [22:0] frac;
    logic [8:0]  expo;
    msb = 5'd0;
    for (int i = 0; i < PIX_W; i++) begin
      if (n[i]) msb = 5'(i);
    end
    frac = 23'({n, 23'd0} >> msb);
    expo = 9'd256 + {4'd0, msb};
    if (n == '0) return 33'd0;
    return {1'b0, expo, frac};
  endfunction

  assign w_cxmax  = (tri_xmax > c_X_LIM) ? c_X_LIM : tri_xmax;
  assign w_cymax  = (tri_ymax > c_Y_LIM) ? c_Y_LIM : tri_ymax;
  assign w_empty  = (tri_xmin > w_cxmax) || (tri_ymin > w_cymax);
  assign w_accept = (r_state == S_IDLE) && r_tri_ready && tri_valid;
  assign w_adv    = (r_state == S_SCAN) && r_pix_valid && pix_ready;
  assign w_x_end  = (r_x == r_cxmax);
  assign w_y_end  = (r_y == r_cymax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_xmin      <= '0;
      r_cxmax     <= '0;
      r_cymax     <= '0;
      r_tri_ready <= 1'b0;
      r_pix_valid <= 1'b0;
      r_tri_done  <= 1'b0;
      r_pa        <= '0;
      r_pb        <= '0;
      r_pc        <= '0;
      r_wind      <= 1'b0;
      r_orig      <= 1'b0;
      r_area      <= 1'b0;
    end else begin
      r_tri_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tri_ready <= 1'b1;
          r_pix_valid <= 1'b0;
          if (w_accept) begin
            r_pa    <= tri_Pa;
            r_pb    <= tri_Pb;
            r_pc    <= tri_Pc;
            r_wind  <= tri_windingOrder;
            r_orig  <= tri_origin_location;
            r_area  <= tri_areaSign;
            r_xmin  <= tri_xmin;
            r_cxmax <= w_cxmax;
            r_cymax <= w_cymax;
            if (w_empty) begin
              r_tri_done <= 1'b1;
            end else begin
              r_x         <= tri_xmin;
              r_y         <= tri_ymin;
              r_tri_ready <= 1'b0;
              r_pix_valid <= 1'b1;
              r_state     <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_adv) begin
            if (!w_x_end) begin
              r_x <= r_x + 1'b1;
            end else if (!w_y_end) begin
              r_x <= r_xmin;
              r_y <= r_y + 1'b1;
            end else begin
              // Counters stay on the last pixel; tri_done and tri_ready rise together.
              r_state     <= S_IDLE;
              r_pix_valid <= 1'b0;
              r_tri_ready <= 1'b1;
              r_tri_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_pix_valid <= 1'b0;
          r_tri_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tri_ready           = r_tri_ready;
  assign tri_done            = r_tri_done;
  assign pix_valid           = r_pix_valid;
  assign pix_x               = r_x;
  assign pix_y               = r_y;
  assign pix_Pin             = {f_int_to_rec(r_x), f_int_to_rec(r_y)};
  assign pix_Pa              = r_pa;
  assign pix_Pb              = r_pb;
  assign pix_Pc              = r_pc;
  assign pix_windingOrder    = r_wind;
  assign pix_origin_location = r_orig;
  assign pix_areaSign        = r_area;
  assign pix_last            = (r_state == S_SCAN) && w_x_end && w_y_end;

endmodule
`default_nettype wire

// File: tb/tb_tri_bbox_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_bbox_scanner
// Purpose  : Directed and randomized triangles against a raster-order model.
// Revision : 1.0
// ============================================================================
module tb_tri_bbox_scanner;

  localparam int PIX_W = 16;
  localparam int SW    = 640;
  localparam int SH    = 480;

  logic             clk;
  logic             rst;
  logic             tri_valid;
  logic             tri_ready;
  logic [65:0]      tri_Pa, tri_Pb, tri_Pc;
  logic [PIX_W-1:0] tri_xmin, tri_xmax, tri_ymin, tri_ymax;
  logic             tri_windingOrder, tri_origin_location, tri_areaSign;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_x, pix_y;
  logic [65:0]      pix_Pin, pix_Pa, pix_Pb, pix_Pc;
  logic             pix_windingOrder, pix_origin_location, pix_areaSign;
  logic             pix_last;
  logic             tri_done;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pt_t;

  tri_bbox_scanner #(.PIX_W(PIX_W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tri_valid           (tri_valid),
    .tri_ready           (tri_ready),
    .tri_Pa              (tri_Pa),
    .tri_Pb              (tri_Pb),
    .tri_Pc              (tri_Pc),
    .tri_xmin            (tri_xmin),
    .tri_xmax            (tri_xmax),
    .tri_ymin            (tri_ymin),
    .tri_ymax            (tri_ymax),
    .tri_windingOrder    (tri_windingOrder),
    .tri_origin_location (tri_origin_location),
    .tri_areaSign        (tri_areaSign),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .pix_x               (pix_x),
    .pix_y               (pix_y),
    .pix_Pin             (pix_Pin),
    .pix_Pa              (pix_Pa),
    .pix_Pb              (pix_Pb),
    .pix_Pc              (pix_Pc),
    .pix_windingOrder    (pix_windingOrder),
    .pix_origin_location (pix_origin_location),
    .pix_areaSign        (pix_areaSign),
    .pix_last            (pix_last),
    .tri_done            (tri_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [65:0] act, input logic [65:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference recoding via the double-precision bit pattern of the integer.
  function automatic logic [32:0] ref_rec(input int unsigned n);
    logic [63:0] d;
    int          e;
    if (n == 0) return 33'd0;
    d = $realtobits(real'(n));
    e = int'(d[62:52]) - 1023;
    return {1'b0, 9'(e + 256), d[51:29]};
  endfunction

  function automatic logic [65:0] rnd66();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // mode 0: always ready; 1: ready pattern 1,0,0; 2: random ready and junk tri_valid in SCAN
  task automatic run_tri(input int xmin, input int xmax, input int ymin, input int ymax, input int mode);
    pt_t         exp_q[$];
    logic [65:0] va, vb, vc;
    logic [2:0]  vm;
    int          cx, cy, cyc, k;
    logic        pr;
    cx = (xmax > SW - 1) ? SW - 1 : xmax;
    cy = (ymax > SH - 1) ? SH - 1 : ymax;
    for (int y = ymin; y <= cy; y++)
      for (int x = xmin; x <= cx; x++)
        exp_q.push_back('{x: 16'(x), y: 16'(y)});
    va = rnd66(); vb = rnd66(); vc = rnd66(); vm = 3'($urandom());

    @(negedge clk);
    check_val("ready_idle", tri_ready, 1);
    check_val("done_idle", tri_done, 0);
    check_val("valid_idle", pix_valid, 0);
    tri_xmin = 16'(xmin); tri_xmax = 16'(xmax);
    tri_ymin = 16'(ymin); tri_ymax = 16'(ymax);
    tri_Pa = va; tri_Pb = vb; tri_Pc = vc;
    {tri_windingOrder, tri_origin_location, tri_areaSign} = vm;
    tri_valid = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
    tri_Pa = rnd66(); tri_Pb = rnd66(); tri_Pc = rnd66();
    tri_xmin = 16'($urandom_range(0, 20)); tri_ymin = 16'($urandom_range(0, 20));

    if (exp_q.size() == 0) begin
      @(negedge clk);
      check_val("empty_done", tri_done, 1);
      check_val("empty_valid", pix_valid, 0);
      check_val("empty_ready", tri_ready, 1);
      @(negedge clk);
      check_val("empty_done_pulse", tri_done, 0);
      check_val("empty_valid2", pix_valid, 0);
      return;
    end

    cyc = 0;
    k   = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      @(negedge clk);
      case (mode)
        0:       pr = 1'b1;
        1:       pr = (k % 3 == 0);
        default: pr = 1'($urandom_range(0, 1));
      endcase
      pix_ready = pr;
      tri_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pr && exp_q.size() == 1) tri_valid = 1'b0;
      k++;
      cyc++;
      check_val("pix_valid", pix_valid, 1);
      check_val("pix_x", pix_x, exp_q[0].x);
      check_val("pix_y", pix_y, exp_q[0].y);
      check_val("pix_Pin", pix_Pin, {ref_rec(32'(exp_q[0].x)), ref_rec(32'(exp_q[0].y))});
      if (exp_q[0].x == 16'd3) check_val("pin_x3", pix_Pin[65:33], 33'h080C00000);
      check_val("pix_last", pix_last, (exp_q.size() == 1));
      check_val("pix_Pa", pix_Pa, va);
      check_val("pix_Pb", pix_Pb, vb);
      check_val("pix_Pc", pix_Pc, vc);
      check_val("pix_mode", {pix_windingOrder, pix_origin_location, pix_areaSign}, vm);
      check_val("scan_ready", tri_ready, 0);
      check_val("scan_done", tri_done, 0);
      if (pr) void'(exp_q.pop_front());
    end
    if (exp_q.size() != 0) check_val("scan_timeout", exp_q.size(), 0);
    tri_valid = 1'b0;
    @(negedge clk);
    pix_ready = 1'b1;
    check_val("end_done", tri_done, 1);
    check_val("end_ready", tri_ready, 1);
    check_val("end_valid", pix_valid, 0);
    check_val("end_last", pix_last, 0);
  endtask

  initial begin
    int xmin, xmax, ymin, ymax;
    rst = 1'b1;
    tri_valid = 1'b0;
    pix_ready = 1'b1;
    tri_Pa = '0; tri_Pb = '0; tri_Pc = '0;
    tri_xmin = '0; tri_xmax = '0; tri_ymin = '0; tri_ymax = '0;
    tri_windingOrder = 1'b0; tri_origin_location = 1'b0; tri_areaSign = 1'b0;

    #12;
    check_val("rst_ready", tri_ready, 0);
    check_val("rst_valid", pix_valid, 0);
    check_val("rst_done", tri_done, 0);
    check_val("rst_last", pix_last, 0);
    check_val("rst_xy", {pix_x, pix_y}, 0);
    check_val("rst_pin", pix_Pin, 0);
    check_val("rst_pa", pix_Pa, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", tri_ready, 1);

    run_tri(2, 3, 5, 6, 0);
    run_tri(2, 3, 5, 6, 1);
    run_tri(10, 4, 0, 3, 0);
    run_tri(638, 700, 479, 500, 0);
    run_tri(0, 0, 0, 0, 0);

    // Reset after two of four pixels have been consumed.
    @(negedge clk);
    tri_xmin = 16'd0; tri_xmax = 16'd1; tri_ymin = 16'd0; tri_ymax = 16'd1;
    tri_valid = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk);
    #1 tri_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", pix_valid, 0);
    check_val("mid_rst_done", tri_done, 0);
    check_val("mid_rst_ready", tri_ready, 0);
    check_val("mid_rst_xy", {pix_x, pix_y}, 0);
    check_val("mid_rst_last", pix_last, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mid_rst_nodone", tri_done, 0);
      check_val("mid_rst_novalid", pix_valid, 0);
    end
    run_tri(1, 1, 1, 1, 0);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        xmin = $urandom_range(630, 645);
        ymin = $urandom_range(470, 485);
      end else begin
        xmin = $urandom_range(0, 40);
        ymin = $urandom_range(0, 40);
      end
      xmax = xmin + $urandom_range(0, 6);
      ymax = ymin + $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) xmax = (xmin > 3) ? xmin - 3 : xmin;
      run_tri(xmin, xmax, ymin, ymax, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
